// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] XZR = 5'd31;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [63:0]       wd;
  } wb_req_t;

  function automatic logic [31:0] onehot_wa(input logic [REG_AW-1:0] wa);
    return 32'd1 << wa;
  endfunction

endpackage

// File: rtl/regfile_writer_if.sv
// Writeback channels (ALU, load) and regfile write-port bundle for regfile_writer.
interface regfile_writer_if #(
  parameter int unsigned DW = wb_pkg::DW
) ();

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_wa;
  logic [DW-1:0] alu_wd;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_wa;
  logic [DW-1:0] mem_wd;
  logic          we3;
  logic [4:0]    wa3;
  logic [DW-1:0] wd3;
  logic [31:0]   pend;

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    input  alu_ready, mem_ready, we3, wa3, wd3, pend
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    output alu_ready, mem_ready, we3, wa3, wd3, pend
  );

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry writeback request FIFO with a per-entry valid/address view for hazard tracking.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output wb_req_t                      pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_wa
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Push and pop never target the same slot: push needs !full, pop needs !empty.
  always_comb begin
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign ent_vld  = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_wa[i] = mem_q[i].wa;
  end

endmodule

// File: rtl/regfile_writer.sv
// Regfile write-side controller: two writeback FIFOs, round-robin retire, XZR drop, pend mask.
// Optional WB_BYPASS_EN lets a granted transfer into an empty channel skip its FIFO.
module regfile_writer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = wb_pkg::DW
) (
  input logic              clk,
  input logic              reset,
  regfile_writer_if.slave  bus
);

  localparam logic RrAlu = 1'b0;
  localparam logic RrMem = 1'b1;

  wb_req_t alu_in, mem_in, alu_head, mem_head, sel;
  logic alu_full, alu_empty, mem_full, mem_empty;
  logic alu_acc, mem_acc, alu_keep, mem_keep;
  logic alu_byp_cand, mem_byp_cand, alu_avail, mem_avail;
  logic gnt_alu, gnt_mem, alu_pop, mem_pop, alu_byp, mem_byp, alu_push, mem_push;
  logic [DEPTH-1:0]             alu_ent_vld, mem_ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] alu_ent_wa, mem_ent_wa;

  logic          rr_q, rr_d;
  logic          we3_q;
  logic [4:0]    wa3_q;
  logic [DW-1:0] wd3_q;

  assign alu_in   = '{wa: bus.alu_wa, wd: bus.alu_wd};
  assign mem_in   = '{wa: bus.mem_wa, wd: bus.mem_wd};
  assign alu_acc  = bus.alu_valid & ~alu_full;
  assign mem_acc  = bus.mem_valid & ~mem_full;
  // XZR writes complete the handshake but are never queued.
  assign alu_keep = alu_acc & (bus.alu_wa != XZR);
  assign mem_keep = mem_acc & (bus.mem_wa != XZR);

`ifdef WB_BYPASS_EN
  assign alu_byp_cand = alu_keep & alu_empty;
  assign mem_byp_cand = mem_keep & mem_empty;
`else
  assign alu_byp_cand = 1'b0;
  assign mem_byp_cand = 1'b0;
`endif

  assign alu_avail = ~alu_empty | alu_byp_cand;
  assign mem_avail = ~mem_empty | mem_byp_cand;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    rr_d    = rr_q;
    if (alu_avail && mem_avail) begin
      gnt_alu = (rr_q == RrAlu);
      gnt_mem = (rr_q == RrMem);
      rr_d    = ~rr_q;
    end else if (alu_avail) begin
      gnt_alu = 1'b1;
    end else if (mem_avail) begin
      gnt_mem = 1'b1;
    end
  end

  assign alu_pop  = gnt_alu & ~alu_empty;
  assign mem_pop  = gnt_mem & ~mem_empty;
  assign alu_byp  = gnt_alu & alu_empty;
  assign mem_byp  = gnt_mem & mem_empty;
  assign alu_push = alu_keep & ~alu_byp;
  assign mem_push = mem_keep & ~mem_byp;

  always_comb begin
    sel = mem_pop ? mem_head : mem_in;
    if (gnt_alu) sel = alu_pop ? alu_head : alu_in;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (alu_push),
    .push_data (alu_in),
    .pop       (alu_pop),
    .pop_data  (alu_head),
    .full      (alu_full),
    .empty     (alu_empty),
    .ent_vld   (alu_ent_vld),
    .ent_wa    (alu_ent_wa)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_push),
    .push_data (mem_in),
    .pop       (mem_pop),
    .pop_data  (mem_head),
    .full      (mem_full),
    .empty     (mem_empty),
    .ent_vld   (mem_ent_vld),
    .ent_wa    (mem_ent_wa)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= RrAlu;
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      rr_q  <= rr_d;
      we3_q <= gnt_alu | gnt_mem;
      if (gnt_alu || gnt_mem) begin
        wa3_q <= sel.wa;
        wd3_q <= sel.wd;
      end
    end
  end

  always_comb begin
    bus.pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ent_vld[i]) bus.pend = bus.pend | onehot_wa(alu_ent_wa[i]);
      if (mem_ent_vld[i]) bus.pend = bus.pend | onehot_wa(mem_ent_wa[i]);
    end
    if (we3_q) bus.pend = bus.pend | onehot_wa(wa3_q);
  end

  assign bus.alu_ready = ~alu_full;
  assign bus.mem_ready = ~mem_full;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Randomized bench for regfile_writer against a queue-based reference model.
module tb_regfile_writer;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writer_if #(.DW(64)) bus ();

  regfile_writer #(.DEPTH(DEPTH), .DW(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  wb_req_t alu_q[$];
  wb_req_t mem_q[$];
  bit      m_we;
  wb_req_t m_out;
  bit      m_rr;       // 0: ALU has priority on the next tie
  bit      last_acc_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (alu_q[i]) p[alu_q[i].wa] = 1'b1;
    foreach (mem_q[i]) p[mem_q[i].wa] = 1'b1;
    if (m_we) p[m_out.wa] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    alu_q.delete();
    mem_q.delete();
    m_we  = 1'b0;
    m_out = '0;
    m_rr  = 1'b0;
  endtask

  // Applies one posedge worth of behaviour using the inputs present at that edge.
  task automatic model_step();
    bit acc_a, acc_m, keep_a, keep_m, has_a, has_m, byp_a, byp_m;
    int g;
    wb_req_t in_a, in_m;
    in_a   = '{wa: bus.alu_wa, wd: bus.alu_wd};
    in_m   = '{wa: bus.mem_wa, wd: bus.mem_wd};
    acc_a  = bus.alu_valid && (alu_q.size() < DEPTH);
    acc_m  = bus.mem_valid && (mem_q.size() < DEPTH);
    keep_a = acc_a && (in_a.wa != 5'd31);
    keep_m = acc_m && (in_m.wa != 5'd31);
    has_a  = (alu_q.size() > 0) || (BYP && keep_a);
    has_m  = (mem_q.size() > 0) || (BYP && keep_m);
    g = -1;
    if (has_a && has_m) begin
      g    = m_rr ? 1 : 0;
      m_rr = !m_rr;
    end else if (has_a) begin
      g = 0;
    end else if (has_m) begin
      g = 1;
    end
    byp_a = 1'b0;
    byp_m = 1'b0;
    m_we  = (g >= 0);
    if (g == 0) begin
      if (alu_q.size() > 0) m_out = alu_q.pop_front();
      else begin m_out = in_a; byp_a = 1'b1; end
    end else if (g == 1) begin
      if (mem_q.size() > 0) m_out = mem_q.pop_front();
      else begin m_out = in_m; byp_m = 1'b1; end
    end
    if (keep_a && !byp_a) alu_q.push_back(in_a);
    if (keep_m && !byp_m) mem_q.push_back(in_m);
    last_acc_a = acc_a;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_alu_ready"}, 64'(bus.alu_ready), 64'(alu_q.size() < DEPTH));
    chk({ph, "_mem_ready"}, 64'(bus.mem_ready), 64'(mem_q.size() < DEPTH));
    chk({ph, "_we3"}, 64'(bus.we3), 64'(m_we));
    chk({ph, "_wa3"}, 64'(bus.wa3), 64'(m_out.wa));
    chk({ph, "_wd3"}, bus.wd3, m_out.wd);
    chk({ph, "_pend"}, 64'(bus.pend), 64'(model_pend()));
  endtask

  task automatic drive(input bit va, input logic [4:0] wa_a, input logic [63:0] wd_a,
                       input bit vm, input logic [4:0] wa_m, input logic [63:0] wd_m);
    bus.alu_valid = va;
    bus.alu_wa    = wa_a;
    bus.alu_wd    = wd_a;
    bus.mem_valid = vm;
    bus.mem_wa    = wa_m;
    bus.mem_wd    = wd_m;
  endtask

  // Called just after a negedge: drive, clock, update model, check at the next negedge.
  task automatic cycle(input string ph, input bit va, input logic [4:0] wa_a,
                       input logic [63:0] wd_a, input bit vm, input logic [4:0] wa_m,
                       input logic [63:0] wd_m);
    drive(va, wa_a, wd_a, vm, wa_m, wd_m);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic async_reset(input string ph);
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk({ph, "_we3"}, 64'(bus.we3), 64'd0);
    chk({ph, "_pend"}, 64'(bus.pend), 64'd0);
    chk({ph, "_alu_ready"}, 64'(bus.alu_ready), 64'd1);
    chk({ph, "_mem_ready"}, 64'(bus.mem_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int sent;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    reset = 1'b1;
    model_clear();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("rst");
    reset = 1'b1;

    // Single ALU write
    cycle("t1", 1'b1, 5'd1, 64'hCAFE_CAFE_CAFE, 1'b0, 5'd0, 64'd0);
    chk("t1_pend1_after_accept", 64'(bus.pend[1]), 64'd1);
    idle("t1i", 3);
    chk("t1_pend_clear", 64'(bus.pend), 64'd0);

    // XZR write on load channel is swallowed
    cycle("t2", 1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEAD);
    idle("t2i", 3);
    chk("t2_pend_zero", 64'(bus.pend), 64'd0);

    // Both channels streaming
    for (int i = 0; i < 6; i++)
      cycle("t3", 1'b1, 5'(2 + i), rnd64(), 1'b1, 5'(10 + i), rnd64());
    idle("t3i", 6);

    // ALU fills while MEM keeps competing
    sent = 0;
    for (int c = 0; c < 16 && sent < 3; c++) begin
      cycle("t4", 1'b1, 5'(3 + sent), rnd64(), 1'b1, 5'(16 + (c % 8)), rnd64());
      if (last_acc_a) sent++;
    end
    chk("t4_alu_sent", 64'(sent), 64'd3);
    idle("t4i", 6);

    // Reset with writes queued
    cycle("t5a", 1'b1, 5'd5, rnd64(), 1'b1, 5'd20, rnd64());
    cycle("t5b", 1'b1, 5'd6, rnd64(), 1'b1, 5'd21, rnd64());
    async_reset("t5rst");
    idle("t5i", 4);

    // Accept-to-we3 latency from idle
    drive(1'b1, 5'd5, 64'd7, 1'b0, 5'd0, 64'd0);
    @(posedge clk);
    model_step();
    #1 chk("t6_we3_accept_edge", 64'(bus.we3), BYP ? 64'd1 : 64'd0);
    @(negedge clk);
    check_outputs("t6");
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    @(posedge clk);
    model_step();
    #1 chk("t6_we3_next_edge", 64'(bus.we3), BYP ? 64'd0 : 64'd1);
    chk("t6_wa3", 64'(bus.wa3), 64'd5);
    @(negedge clk);
    check_outputs("t6n");
    idle("t6i", 2);

    // Random traffic; ALU uses X0-X15, MEM X16-X31 so no register is in flight on both
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rnd_rst");
      cycle("rnd", $urandom_range(0, 3) != 0, 5'($urandom_range(0, 15)), rnd64(),
            $urandom_range(0, 2) != 0, 5'($urandom_range(16, 31)), rnd64());
    end
    idle("drain", 6);
    chk("drain_pend", 64'(bus.pend), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
